// File: rtl/vector_message_passer.sv
// vector_message_passer: a mesh node holding two operand vectors (A, B) and a
// signed accumulator. A host drives one opcode per ack handshake; operands can
// be loaded from the four neighbours or from the host, and a multiply-
// accumulate folds the lane-wise dot product of A and B into s_out.
module vector_message_passer #(
    parameter int PRECISION        = 8,
    parameter int LANES            = 4,
    parameter int OUTPUT_PRECISION = 32,
    parameter int MAC_STAGES       = 2,
    parameter int SATURATE         = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          ack,
    output logic                          ready,
    input  logic [3:0]                    command_to_execute,
    input  logic [LANES*PRECISION-1:0]    isu,
    input  logic [LANES*PRECISION-1:0]    isd,
    input  logic [LANES*PRECISION-1:0]    isl,
    input  logic [LANES*PRECISION-1:0]    isr,
    output logic [LANES*PRECISION-1:0]    osu,
    output logic [LANES*PRECISION-1:0]    osd,
    output logic [LANES*PRECISION-1:0]    osl,
    output logic [LANES*PRECISION-1:0]    osr,
    input  logic [LANES*PRECISION-1:0]    a_overwrite,
    input  logic [LANES*PRECISION-1:0]    b_overwrite,
    input  logic [OUTPUT_PRECISION-1:0]   s_out_overwrite,
    output logic [LANES*PRECISION-1:0]    A,
    output logic [LANES*PRECISION-1:0]    B,
    output logic [OUTPUT_PRECISION-1:0]   s_out,
    output logic                          sat_flag
);

    localparam int VW     = LANES * PRECISION;
    localparam int PROD_W = 2 * PRECISION;
    // Sum of LANES full-width products plus one spare bit of headroom.
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
    // Wide enough to hold accumulator + dot product without overflow.
    localparam int ACC_W  = ((SUM_W > OUTPUT_PRECISION) ? SUM_W : OUTPUT_PRECISION) + 1;
    // MAC_STAGES is limited to 1..4, so a 2-bit stage counter suffices.
    localparam int CNT_W  = 2;
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(MAC_STAGES - 1);

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_A_UP    = 4'h1;
    localparam logic [3:0] OP_A_DOWN  = 4'h2;
    localparam logic [3:0] OP_B_LEFT  = 4'h3;
    localparam logic [3:0] OP_B_RIGHT = 4'h4;
    localparam logic [3:0] OP_A_HOST  = 4'h5;
    localparam logic [3:0] OP_B_HOST  = 4'h6;
    localparam logic [3:0] OP_S_HOST  = 4'h7;
    localparam logic [3:0] OP_MAC     = 4'h8;
    localparam logic [3:0] OP_S_CLR   = 4'h9;
    localparam logic [3:0] OP_SWAP    = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  op_q, op_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [VW-1:0]               a_q, a_d;
    logic [VW-1:0]               b_q, b_d;
    logic [OUTPUT_PRECISION-1:0] s_q, s_d;
    logic                        sat_q, sat_d;

    logic signed [SUM_W-1:0]            dot;
    logic signed [ACC_W-1:0]            acc_sum;
    logic [ACC_W-OUTPUT_PRECISION:0]    acc_top;
    logic                               acc_ovf;
    logic                               mac_sat;
    logic [OUTPUT_PRECISION-1:0]        mac_result;
    logic                               exec_last;

    assign ready    = (state_q == ST_IDLE);
    assign A        = a_q;
    assign B        = b_q;
    assign s_out    = s_q;
    assign sat_flag = sat_q;
    assign osu      = a_q;
    assign osd      = a_q;
    assign osl      = b_q;
    assign osr      = b_q;

    // Signed lane-wise dot product of A and B at full width.
    always_comb begin
        logic signed [PRECISION-1:0] ea;
        logic signed [PRECISION-1:0] eb;
        logic signed [PROD_W-1:0]    prod;
        dot  = '0;
        ea   = '0;
        eb   = '0;
        prod = '0;
        for (int i = 0; i < LANES; i++) begin
            ea   = a_q[i*PRECISION +: PRECISION];
            eb   = b_q[i*PRECISION +: PRECISION];
            prod = PROD_W'(ea) * PROD_W'(eb);
            dot  = dot + SUM_W'(prod);
        end
    end

    // Accumulate and either clamp to the signed output range or wrap.
    always_comb begin
        acc_sum = ACC_W'($signed(s_q)) + ACC_W'(dot);
        // The result fits iff every bit from the output sign bit upward agrees.
        acc_top = acc_sum[ACC_W-1:OUTPUT_PRECISION-1];
        acc_ovf = !((&acc_top) || !(|acc_top));
        mac_sat = (SATURATE != 0) && acc_ovf;
        if (mac_sat) begin
            mac_result = acc_sum[ACC_W-1] ? {1'b1, {(OUTPUT_PRECISION-1){1'b0}}}
                                          : {1'b0, {(OUTPUT_PRECISION-1){1'b1}}};
        end else begin
            mac_result = acc_sum[OUTPUT_PRECISION-1:0];
        end
    end

    // Handshake FSM and register updates on the final EXEC edge.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        sat_d     = sat_q;
        exec_last = (op_q != OP_MAC) || (cnt_q == LAST_STAGE);

        case (state_q)
            ST_IDLE: begin
                if (ack) begin
                    op_d    = command_to_execute;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_last) begin
                    state_d = ST_HOLD;
                    case (op_q)
                        OP_A_UP:    a_d = isu;
                        OP_A_DOWN:  a_d = isd;
                        OP_B_LEFT:  b_d = isl;
                        OP_B_RIGHT: b_d = isr;
                        OP_A_HOST:  a_d = a_overwrite;
                        OP_B_HOST:  b_d = b_overwrite;
                        OP_S_HOST: begin
                            s_d   = s_out_overwrite;
                            sat_d = 1'b0;
                        end
                        OP_MAC: begin
                            s_d = mac_result;
                            if (mac_sat) sat_d = 1'b1;
                        end
                        OP_S_CLR: begin
                            s_d   = '0;
                            sat_d = 1'b0;
                        end
                        OP_SWAP: begin
                            a_d = b_q;
                            b_d = a_q;
                        end
                        default: ;  // OP_NOP and reserved opcodes leave state alone
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset that overrides any handshake.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (RST) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sat_q   <= sat_d;
        end
    end

endmodule
